// File: rtl/decode_pkg.sv
// Decode-stage types: immediate selector, ALU operation and funct7 constants.
package decode_pkg;
    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_IZ, IMM_S, IMM_SB, IMM_U, IMM_UJ
    } imm_sel_e;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_PASS_B,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    localparam logic [6:0] FUNCT7_BASE   = 7'h00;
    localparam logic [6:0] FUNCT7_ALT    = 7'h20;
    localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

    // alt selects SUB/SRA in place of ADD/SRL
    function automatic alu_op_e base_alu_op(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic alu_op_e muldiv_alu_op(input logic [2:0] funct3);
        alu_op_e op;
        case (funct3)
            3'b000:  op = ALU_MUL;
            3'b001:  op = ALU_MULH;
            3'b010:  op = ALU_MULHSU;
            3'b011:  op = ALU_MULHU;
            3'b100:  op = ALU_DIV;
            3'b101:  op = ALU_DIVU;
            3'b110:  op = ALU_REM;
            default: op = ALU_REMU;
        endcase
        return op;
    endfunction
endpackage

// File: rtl/riscv_defines.sv
// RV32 base opcode values (instr[6:0]) shared by the decode logic.
package riscv_defines;
    localparam logic [6:0] OPCODE_LOAD     = 7'h03;
    localparam logic [6:0] OPCODE_LOAD_FP  = 7'h07;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'h0F;
    localparam logic [6:0] OPCODE_OPIMM    = 7'h13;
    localparam logic [6:0] OPCODE_AUIPC    = 7'h17;
    localparam logic [6:0] OPCODE_STORE    = 7'h23;
    localparam logic [6:0] OPCODE_STORE_FP = 7'h27;
    localparam logic [6:0] OPCODE_OP       = 7'h33;
    localparam logic [6:0] OPCODE_LUI      = 7'h37;
    localparam logic [6:0] OPCODE_FMADD    = 7'h43;
    localparam logic [6:0] OPCODE_FMSUB    = 7'h47;
    localparam logic [6:0] OPCODE_FNMSUB   = 7'h4B;
    localparam logic [6:0] OPCODE_FNMADD   = 7'h4F;
    localparam logic [6:0] OPCODE_OP_FP    = 7'h53;
    localparam logic [6:0] OPCODE_BRANCH   = 7'h63;
    localparam logic [6:0] OPCODE_JALR     = 7'h67;
    localparam logic [6:0] OPCODE_JAL      = 7'h6F;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'h73;
endpackage

// File: rtl/imm_gen.sv
// Combinational RV32 immediate extraction; IZ is the zero-extended CSR uimm (rs1 field).
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_sel_e    imm_sel,
    output logic [31:0] imm
);
    always_comb begin
        case (imm_sel)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_IZ:  imm = {27'b0, instr[19:15]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_SB:  imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_UJ:  imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// Registered RV32 decode stage with valid/ready handshake, flush and illegal detection.
module decode_stage
    import decode_pkg::*;
    import riscv_defines::*;
#(
    parameter int GP_REG_COUNT = 32,
    parameter bit ENABLE_M     = 1'b0,
    parameter bit ENABLE_FP    = 1'b0,
    localparam int AW = $clog2(GP_REG_COUNT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   instr_i,
    input  logic [31:0]   instr_addr_i,
    input  logic          instr_valid_i,
    output logic          instr_ready_o,
    input  logic          flush_i,
    output logic [AW-1:0] rf_rs1_addr_o,
    output logic [AW-1:0] rf_rs2_addr_o,
    output logic          id_valid_o,
    input  logic          id_ready_i,
    output logic [31:0]   id_pc_o,
    output logic [AW-1:0] id_rd_addr_o,
    output logic          id_rf_we_o,
    output logic [31:0]   id_imm_o,
    output alu_op_e       id_alu_op_o,
    output logic          id_alu_src_imm_o,
    output logic          id_alu_src_pc_o,
    output logic          id_mem_req_o,
    output logic          id_mem_we_o,
    output logic [2:0]    id_mem_size_o,
    output logic          id_branch_o,
    output logic          id_jal_o,
    output logic          id_jalr_o,
    output logic          id_illegal_o
);
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];

    assign rf_rs1_addr_o = rs1[AW-1:0];
    assign rf_rs2_addr_o = rs2[AW-1:0];

    imm_sel_e    imm_sel;
    alu_op_e     alu_op;
    logic [31:0] imm_raw;
    logic        use_rd, use_rs1, use_rs2, known, bad;
    logic        rf_we, src_imm, src_pc, mem_req, mem_we, branch, jal, jalr;
    logic        reg_oob, illegal, load_en;

    imm_gen u_imm_gen (
        .instr   (instr_i[31:7]),
        .imm_sel (imm_sel),
        .imm     (imm_raw)
    );

    always_comb begin
        imm_sel = IMM_NONE;
        alu_op  = ALU_ADD;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        known   = 1'b1;
        bad     = 1'b0;
        rf_we   = 1'b0;
        src_imm = 1'b0;
        src_pc  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        branch  = 1'b0;
        jal     = 1'b0;
        jalr    = 1'b0;
        case (opcode)
            OPCODE_LUI: begin
                imm_sel = IMM_U; alu_op = ALU_PASS_B; src_imm = 1'b1; rf_we = 1'b1; use_rd = 1'b1;
            end
            OPCODE_AUIPC: begin
                imm_sel = IMM_U; src_pc = 1'b1; src_imm = 1'b1; rf_we = 1'b1; use_rd = 1'b1;
            end
            OPCODE_JAL: begin
                imm_sel = IMM_UJ; jal = 1'b1; src_pc = 1'b1; rf_we = 1'b1; use_rd = 1'b1;
            end
            OPCODE_JALR: begin
                imm_sel = IMM_I; jalr = 1'b1; src_pc = 1'b1; rf_we = 1'b1;
                use_rd = 1'b1; use_rs1 = 1'b1;
            end
            OPCODE_BRANCH: begin
                imm_sel = IMM_SB; branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                alu_op = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            end
            OPCODE_LOAD: begin
                imm_sel = IMM_I; mem_req = 1'b1; src_imm = 1'b1; rf_we = 1'b1;
                use_rd = 1'b1; use_rs1 = 1'b1;
            end
            OPCODE_STORE: begin
                imm_sel = IMM_S; mem_req = 1'b1; mem_we = 1'b1; src_imm = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPCODE_OPIMM: begin
                imm_sel = IMM_I; src_imm = 1'b1; rf_we = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
                alu_op = base_alu_op(funct3, funct3 == 3'b101 && funct7 == FUNCT7_ALT);
                // immediate shifts reuse funct7 as a sub-opcode
                if (funct3 == 3'b001)
                    bad = funct7 != FUNCT7_BASE;
                else if (funct3 == 3'b101)
                    bad = funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT;
            end
            OPCODE_OP: begin
                rf_we = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                if (funct7 == FUNCT7_MULDIV) begin
                    alu_op = muldiv_alu_op(funct3);
                    bad    = !ENABLE_M;
                end else if (funct7 == FUNCT7_ALT) begin
                    alu_op = base_alu_op(funct3, 1'b1);
                    bad    = funct3 != 3'b000 && funct3 != 3'b101;
                end else if (funct7 == FUNCT7_BASE) begin
                    alu_op = base_alu_op(funct3, 1'b0);
                end else begin
                    bad = 1'b1;
                end
            end
            OPCODE_MISC_MEM: ;
            OPCODE_SYSTEM: begin
                if (funct3 != 3'b000) begin
                    rf_we   = 1'b1;
                    use_rd  = 1'b1;
                    use_rs1 = !funct3[2];
                    imm_sel = funct3[2] ? IMM_IZ : IMM_NONE;
                end
            end
            OPCODE_LOAD_FP: begin
                imm_sel = IMM_I; mem_req = 1'b1; src_imm = 1'b1; use_rs1 = 1'b1; bad = !ENABLE_FP;
            end
            OPCODE_STORE_FP: begin
                imm_sel = IMM_S; mem_req = 1'b1; mem_we = 1'b1; src_imm = 1'b1;
                use_rs1 = 1'b1; bad = !ENABLE_FP;
            end
            OPCODE_OP_FP, OPCODE_FMADD, OPCODE_FMSUB, OPCODE_FNMSUB, OPCODE_FNMADD: begin
                bad = !ENABLE_FP;
            end
            default: known = 1'b0;
        endcase
    end

    assign reg_oob = (use_rd  && {1'b0, rd}  >= 6'(GP_REG_COUNT)) ||
                     (use_rs1 && {1'b0, rs1} >= 6'(GP_REG_COUNT)) ||
                     (use_rs2 && {1'b0, rs2} >= 6'(GP_REG_COUNT));
    assign illegal = (instr_i[1:0] != 2'b11) || !known || bad || reg_oob;

    assign instr_ready_o = !id_valid_o || id_ready_i;
    assign load_en       = instr_valid_i && instr_ready_o && !flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_o       <= 1'b0;
            id_pc_o          <= '0;
            id_rd_addr_o     <= '0;
            id_rf_we_o       <= 1'b0;
            id_imm_o         <= '0;
            id_alu_op_o      <= ALU_ADD;
            id_alu_src_imm_o <= 1'b0;
            id_alu_src_pc_o  <= 1'b0;
            id_mem_req_o     <= 1'b0;
            id_mem_we_o      <= 1'b0;
            id_mem_size_o    <= '0;
            id_branch_o      <= 1'b0;
            id_jal_o         <= 1'b0;
            id_jalr_o        <= 1'b0;
            id_illegal_o     <= 1'b0;
        end else begin
            if (flush_i)
                id_valid_o <= 1'b0;
            else if (load_en)
                id_valid_o <= 1'b1;
            else if (id_ready_i)
                id_valid_o <= 1'b0;

            // an illegal word travels as a bubble carrying only its pc, rd and flag
            if (load_en) begin
                id_pc_o          <= instr_addr_i;
                id_rd_addr_o     <= rd[AW-1:0];
                id_rf_we_o       <= rf_we && !illegal && (rd != 5'd0);
                id_imm_o         <= illegal ? 32'd0 : imm_raw;
                id_alu_op_o      <= illegal ? ALU_ADD : alu_op;
                id_alu_src_imm_o <= src_imm && !illegal;
                id_alu_src_pc_o  <= src_pc && !illegal;
                id_mem_req_o     <= mem_req && !illegal;
                id_mem_we_o      <= mem_we && !illegal;
                id_mem_size_o    <= (mem_req && !illegal) ? funct3 : 3'b000;
                id_branch_o      <= branch && !illegal;
                id_jal_o         <= jal && !illegal;
                id_jalr_o        <= jalr && !illegal;
                id_illegal_o     <= illegal;
            end
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Drives an RV32I instance (a) and an RV32E+M+FP instance (b) with shared stimulus.
module tb_decode_stage;
    import decode_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rf_we;
        alu_op_e     alu_op;
        logic        src_imm;
        logic        src_pc;
        logic        mem_req;
        logic        mem_we;
        logic [2:0]  mem_size;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        illegal;
    } exp_t;

    localparam logic [6:0] OP_TAB [18] = '{7'h03, 7'h07, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h27,
        7'h33, 7'h37, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h53, 7'h63, 7'h67, 7'h6F, 7'h73};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_i = '0, instr_addr_i = '0;
    logic        instr_valid_i = 1'b0, flush_i = 1'b0, id_ready_i = 1'b0;

    logic        a_ready, a_valid, a_rf_we, a_src_imm, a_src_pc, a_mem_req, a_mem_we;
    logic        a_branch, a_jal, a_jalr, a_illegal;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [31:0] a_pc, a_imm;
    logic [2:0]  a_mem_size;
    alu_op_e     a_alu_op;

    logic        b_ready, b_valid, b_rf_we, b_src_imm, b_src_pc, b_mem_req, b_mem_we;
    logic        b_branch, b_jal, b_jalr, b_illegal;
    logic [3:0]  b_rs1, b_rs2, b_rd;
    logic [31:0] b_pc, b_imm;
    logic [2:0]  b_mem_size;
    alu_op_e     b_alu_op;

    exp_t obs_a, obs_b;
    exp_t q_a[$], q_b[$];
    int   n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    decode_stage #(.GP_REG_COUNT(32), .ENABLE_M(1'b0), .ENABLE_FP(1'b0)) u_dut_a (
        .clk(clk), .rst(rst), .instr_i(instr_i), .instr_addr_i(instr_addr_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(a_ready), .flush_i(flush_i),
        .rf_rs1_addr_o(a_rs1), .rf_rs2_addr_o(a_rs2), .id_valid_o(a_valid),
        .id_ready_i(id_ready_i), .id_pc_o(a_pc), .id_rd_addr_o(a_rd), .id_rf_we_o(a_rf_we),
        .id_imm_o(a_imm), .id_alu_op_o(a_alu_op), .id_alu_src_imm_o(a_src_imm),
        .id_alu_src_pc_o(a_src_pc), .id_mem_req_o(a_mem_req), .id_mem_we_o(a_mem_we),
        .id_mem_size_o(a_mem_size), .id_branch_o(a_branch), .id_jal_o(a_jal),
        .id_jalr_o(a_jalr), .id_illegal_o(a_illegal)
    );

    decode_stage #(.GP_REG_COUNT(16), .ENABLE_M(1'b1), .ENABLE_FP(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .instr_i(instr_i), .instr_addr_i(instr_addr_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(b_ready), .flush_i(flush_i),
        .rf_rs1_addr_o(b_rs1), .rf_rs2_addr_o(b_rs2), .id_valid_o(b_valid),
        .id_ready_i(id_ready_i), .id_pc_o(b_pc), .id_rd_addr_o(b_rd), .id_rf_we_o(b_rf_we),
        .id_imm_o(b_imm), .id_alu_op_o(b_alu_op), .id_alu_src_imm_o(b_src_imm),
        .id_alu_src_pc_o(b_src_pc), .id_mem_req_o(b_mem_req), .id_mem_we_o(b_mem_we),
        .id_mem_size_o(b_mem_size), .id_branch_o(b_branch), .id_jal_o(b_jal),
        .id_jalr_o(b_jalr), .id_illegal_o(b_illegal)
    );

    always_comb begin
        obs_a = '{pc: a_pc, imm: a_imm, rd: a_rd, rf_we: a_rf_we, alu_op: a_alu_op,
                  src_imm: a_src_imm, src_pc: a_src_pc, mem_req: a_mem_req, mem_we: a_mem_we,
                  mem_size: a_mem_size, branch: a_branch, jal: a_jal, jalr: a_jalr,
                  illegal: a_illegal};
        obs_b = '{pc: b_pc, imm: b_imm, rd: {1'b0, b_rd}, rf_we: b_rf_we, alu_op: b_alu_op,
                  src_imm: b_src_imm, src_pc: b_src_pc, mem_req: b_mem_req, mem_we: b_mem_we,
                  mem_size: b_mem_size, branch: b_branch, jal: b_jal, jalr: b_jalr,
                  illegal: b_illegal};
    end

    // Reference decode straight from the ISA rules, immediates built arithmetically.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input int nregs, input bit en_m, input bit en_fp);
        exp_t e;
        int f3, f7, rd, rs1, rs2, imm_i, imm_s, imm_b, imm_j;
        bit ok, urd, urs1, urs2;
        f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
        rd = int'(ins[11:7]); rs1 = int'(ins[19:15]); rs2 = int'(ins[24:20]);
        imm_i = int'($signed(ins[31:20]));
        imm_s = 32 * int'($signed(ins[31:25])) + int'(ins[11:7]);
        imm_b = -4096 * int'(ins[31]) + 2048 * int'(ins[7]) + 32 * int'(ins[30:25])
                + 2 * int'(ins[11:8]);
        imm_j = -1048576 * int'(ins[31]) + 4096 * int'(ins[19:12]) + 2048 * int'(ins[20])
                + 2 * int'(ins[30:21]);
        e = '0; ok = 1; urd = 0; urs1 = 0; urs2 = 0;
        case (ins[6:0])
            7'h37: begin e.imm = ins & 32'hFFFFF000; e.alu_op = ALU_PASS_B; e.src_imm = 1; e.rf_we = 1; urd = 1; end
            7'h17: begin e.imm = ins & 32'hFFFFF000; e.src_imm = 1; e.src_pc = 1; e.rf_we = 1; urd = 1; end
            7'h6F: begin e.imm = imm_j; e.jal = 1; e.src_pc = 1; e.rf_we = 1; urd = 1; end
            7'h67: begin e.imm = imm_i; e.jalr = 1; e.src_pc = 1; e.rf_we = 1; urd = 1; urs1 = 1; end
            7'h63: begin
                e.imm = imm_b; e.branch = 1; urs1 = 1; urs2 = 1;
                e.alu_op = (f3 >= 6) ? ALU_SLTU : (f3 >= 4) ? ALU_SLT : ALU_SUB;
            end
            7'h03: begin e.imm = imm_i; e.mem_req = 1; e.src_imm = 1; e.rf_we = 1; e.mem_size = 3'(f3); urd = 1; urs1 = 1; end
            7'h23: begin e.imm = imm_s; e.mem_req = 1; e.mem_we = 1; e.src_imm = 1; e.mem_size = 3'(f3); urs1 = 1; urs2 = 1; end
            7'h13: begin
                e.imm = imm_i; e.src_imm = 1; e.rf_we = 1; urd = 1; urs1 = 1;
                if (f3 == 1) begin ok = (f7 == 0); e.alu_op = ALU_SLL; end
                else if (f3 == 5) begin ok = (f7 == 0 || f7 == 32); e.alu_op = (f7 == 32) ? ALU_SRA : ALU_SRL; end
                else e.alu_op = base_alu_op(3'(f3), 1'b0);
            end
            7'h33: begin
                e.rf_we = 1; urd = 1; urs1 = 1; urs2 = 1;
                if (f7 == 1) begin ok = en_m; e.alu_op = muldiv_alu_op(3'(f3)); end
                else if (f7 == 32) begin ok = (f3 == 0 || f3 == 5); e.alu_op = (f3 == 0) ? ALU_SUB : ALU_SRA; end
                else if (f7 == 0) e.alu_op = base_alu_op(3'(f3), 1'b0);
                else ok = 0;
            end
            7'h0F: ;
            7'h73: if (f3 != 0) begin
                e.rf_we = 1; urd = 1;
                if (f3 >= 4) e.imm = rs1; else urs1 = 1;
            end
            7'h07: begin ok = en_fp; e.imm = imm_i; e.mem_req = 1; e.src_imm = 1; e.mem_size = 3'(f3); urs1 = 1; end
            7'h27: begin ok = en_fp; e.imm = imm_s; e.mem_req = 1; e.mem_we = 1; e.src_imm = 1; e.mem_size = 3'(f3); urs1 = 1; end
            7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F: ok = en_fp;
            default: ok = 0;
        endcase
        if ((urd && rd >= nregs) || (urs1 && rs1 >= nregs) || (urs2 && rs2 >= nregs)) ok = 0;
        if (ok) e.rf_we = e.rf_we && (rd != 0);
        else begin e = '0; e.illegal = 1; end
        e.rd = 5'(rd % nregs);
        e.pc = pc;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 19);
        if (k < 18) w[6:0] = OP_TAB[k];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        if ($urandom_range(0, 1) == 1) begin w[11] = 1'b0; w[19] = 1'b0; w[24] = 1'b0; end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({a_valid, a_ready, obs_a} !== {1'b0, 1'b1, exp_t'('0)}) begin
            n_fail++; $display("FAIL reset_a got=%h exp=%h", {a_valid, a_ready, obs_a}, {1'b0, 1'b1, exp_t'('0)});
        end
        n_tests++;
        if ({b_valid, b_ready, obs_b} !== {1'b0, 1'b1, exp_t'('0)}) begin
            n_fail++; $display("FAIL reset_b got=%h exp=%h", {b_valid, b_ready, obs_b}, {1'b0, 1'b1, exp_t'('0)});
        end
        tick();
        rst = 1'b0;
        tick();
        $display("[TB] reset checked");
    endtask

    task automatic test_directed();
        id_ready_i = 1'b1;
        // ADDI x1,x0,-1
        instr_i = 32'hFFF00093; instr_addr_i = 32'h0000_0040; instr_valid_i = 1'b1;
        #2;
        n_tests++;
        if (a_valid !== 1'b0) begin n_fail++; $display("FAIL addi_early got=%b exp=0", a_valid); end
        tick();
        instr_valid_i = 1'b0;
        n_tests++;
        if ({a_valid, a_imm, a_rd, a_rf_we, a_src_imm, a_alu_op} !== {1'b1, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b1, ALU_ADD}) begin
            n_fail++; $display("FAIL addi got=%h exp=%h", {a_valid, a_imm, a_rd, a_rf_we, a_src_imm, a_alu_op},
                               {1'b1, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b1, ALU_ADD});
        end
        // LUI x5,0x12345
        instr_i = 32'h123452B7; instr_valid_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        n_tests++;
        if ({a_valid, a_imm, a_alu_op, a_rf_we, a_rd} !== {1'b1, 32'h12345000, ALU_PASS_B, 1'b1, 5'd5}) begin
            n_fail++; $display("FAIL lui got=%h exp=%h", {a_valid, a_imm, a_alu_op, a_rf_we, a_rd},
                               {1'b1, 32'h12345000, ALU_PASS_B, 1'b1, 5'd5});
        end
        // BEQ x0,x0,-4
        instr_i = 32'hFE000EE3; instr_valid_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        n_tests++;
        if ({a_valid, a_imm, a_branch, a_rf_we, a_illegal} !== {1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL beq got=%h exp=%h", {a_valid, a_imm, a_branch, a_rf_we, a_illegal},
                               {1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0});
        end
        tick();
        n_tests++;
        if (a_valid !== 1'b0) begin n_fail++; $display("FAIL drain got=%b exp=0", a_valid); end
        $display("[TB] directed decodes checked");
    endtask

    task automatic test_illegal();
        id_ready_i = 1'b1;
        // ADD x16,x0,x0: legal on 32 regs, out of range on 16
        instr_i = 32'h00000833; instr_valid_i = 1'b1;
        tick();
        n_tests++;
        if ({a_illegal, a_rf_we, b_illegal, b_rf_we} !== 4'b0110) begin
            n_fail++; $display("FAIL add_x16 got=%b exp=0110", {a_illegal, a_rf_we, b_illegal, b_rf_we});
        end
        // MUL x0,x0,x0: only the M-enabled instance accepts it
        instr_i = 32'h02000033;
        tick();
        instr_valid_i = 1'b0;
        n_tests++;
        if ({a_illegal, b_illegal, b_alu_op} !== {1'b1, 1'b0, ALU_MUL}) begin
            n_fail++; $display("FAIL mul got=%h exp=%h", {a_illegal, b_illegal, b_alu_op}, {1'b1, 1'b0, ALU_MUL});
        end
        tick();
        $display("[TB] illegal detection checked");
    endtask

    task automatic test_backpressure();
        instr_i = 32'h00508193; instr_addr_i = 32'h100; instr_valid_i = 1'b1; id_ready_i = 1'b0;
        tick();
        instr_i = 32'h00A00213; instr_addr_i = 32'h104;
        for (int c = 0; c < 3; c++) begin
            #2;
            n_tests++;
            if ({a_ready, a_valid, a_pc, a_imm, a_rd} !== {1'b0, 1'b1, 32'h100, 32'd5, 5'd3}) begin
                n_fail++; $display("FAIL stall_%0d got=%h exp=%h", c, {a_ready, a_valid, a_pc, a_imm, a_rd},
                                   {1'b0, 1'b1, 32'h100, 32'd5, 5'd3});
            end
            tick();
        end
        id_ready_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        n_tests++;
        if ({a_valid, a_pc, a_imm, a_rd} !== {1'b1, 32'h104, 32'd10, 5'd4}) begin
            n_fail++; $display("FAIL release got=%h exp=%h", {a_valid, a_pc, a_imm, a_rd}, {1'b1, 32'h104, 32'd10, 5'd4});
        end
        tick();
        n_tests++;
        if (a_valid !== 1'b0) begin n_fail++; $display("FAIL no_dup got=%b exp=0", a_valid); end
        $display("[TB] backpressure checked");
    endtask

    task automatic test_flush();
        instr_i = 32'h00108093; instr_addr_i = 32'h200; instr_valid_i = 1'b1; id_ready_i = 1'b0;
        tick();
        instr_i = 32'h12345037; instr_addr_i = 32'h204; flush_i = 1'b1;
        tick();
        flush_i = 1'b0; instr_valid_i = 1'b0;
        n_tests++;
        if ({a_valid, b_valid} !== 2'b00) begin n_fail++; $display("FAIL flush_valid got=%b exp=00", {a_valid, b_valid}); end
        id_ready_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_tests++;
            if ({a_valid, a_pc} !== {1'b0, 32'h200}) begin
                n_fail++; $display("FAIL flush_drop_%0d got=%h exp=%h", c, {a_valid, a_pc}, {1'b0, 32'h200});
            end
        end
        $display("[TB] flush checked");
    endtask

    task automatic test_async_reset();
        instr_i = 32'h00108093; instr_addr_i = 32'h300; instr_valid_i = 1'b1; id_ready_i = 1'b0;
        tick();
        instr_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({a_valid, a_ready, obs_a} !== {1'b0, 1'b1, exp_t'('0)}) begin
            n_fail++; $display("FAIL async_rst got=%h exp=%h", {a_valid, a_ready, obs_a}, {1'b0, 1'b1, exp_t'('0)});
        end
        tick();
        rst = 1'b0;
        instr_i = 32'h00200113; instr_addr_i = 32'h308; instr_valid_i = 1'b1; id_ready_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        n_tests++;
        if ({a_valid, a_pc, a_rd, a_imm} !== {1'b1, 32'h308, 5'd2, 32'd2}) begin
            n_fail++; $display("FAIL post_rst got=%h exp=%h", {a_valid, a_pc, a_rd, a_imm}, {1'b1, 32'h308, 5'd2, 32'd2});
        end
        tick();
        $display("[TB] asynchronous reset checked");
    endtask

    task automatic test_random();
        bit exp_ready;
        q_a.delete(); q_b.delete();
        for (int c = 0; c < 600; c++) begin
            instr_i       = rand_instr();
            instr_addr_i  = $urandom & 32'hFFFF_FFFC;
            instr_valid_i = ($urandom_range(0, 3) != 0);
            id_ready_i    = ($urandom_range(0, 2) != 0);
            flush_i       = ($urandom_range(0, 15) == 0);
            #2;
            exp_ready = (q_a.size() == 0) || id_ready_i;
            n_tests++;
            if ({a_valid, b_valid, a_ready, b_ready} !== {q_a.size() != 0, q_b.size() != 0, exp_ready, exp_ready}) begin
                n_fail++; $display("FAIL rnd_hs cyc=%0d got=%b exp=%b", c, {a_valid, b_valid, a_ready, b_ready},
                                   {q_a.size() != 0, q_b.size() != 0, exp_ready, exp_ready});
            end
            n_tests++;
            if ({a_rs1, a_rs2, b_rs1, b_rs2} !== {instr_i[19:15], instr_i[24:20], instr_i[18:15], instr_i[23:20]}) begin
                n_fail++; $display("FAIL rnd_rf cyc=%0d got=%h instr=%h", c, {a_rs1, a_rs2, b_rs1, b_rs2}, instr_i);
            end
            if (q_a.size() != 0) begin
                n_tests++;
                if (obs_a !== q_a[0]) begin n_fail++; $display("FAIL rnd_a cyc=%0d got=%h exp=%h", c, obs_a, q_a[0]); end
            end
            if (q_b.size() != 0) begin
                n_tests++;
                if (obs_b !== q_b[0]) begin n_fail++; $display("FAIL rnd_b cyc=%0d got=%h exp=%h", c, obs_b, q_b[0]); end
            end
            if (flush_i) begin
                q_a.delete(); q_b.delete();
            end else begin
                if (id_ready_i && q_a.size() != 0) void'(q_a.pop_front());
                if (id_ready_i && q_b.size() != 0) void'(q_b.pop_front());
                if (instr_valid_i && exp_ready) begin
                    q_a.push_back(model(instr_i, instr_addr_i, 32, 1'b0, 1'b0));
                    q_b.push_back(model(instr_i, instr_addr_i, 16, 1'b1, 1'b1));
                end
            end
            tick();
        end
        instr_valid_i = 1'b0; flush_i = 1'b0;
        $display("[TB] random stream of 600 cycles checked");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
